// File: rtl/ammrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ammrt_pkg
// Description : Shared types and helpers for the ammrt round-robin arbiter:
//               FSM state encoding, ID-width helper and round-robin winner
//               selection.
// Revision    : 1.0 - initial release
// ============================================================================
package ammrt_pkg;

  // Arbiter FSM states (explicit 1-bit encoding)
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Largest supported master count and the matching ID width
  localparam int C_MAX_NM  = 8;
  localparam int C_MAX_IDW = 3;

  // Master-ID width: $clog2(nm), never narrower than one bit
  function automatic int f_id_width(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

  // First requester at or after ptr, scanning upward and wrapping at nm.
  // Returns 0 when nothing is requesting (caller only uses it when |req).
  function automatic int f_rr_winner(input logic [C_MAX_NM-1:0] req,
                                     input int ptr, input int nm);
    int   win;
    int   idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < C_MAX_NM; k++) begin
      idx = (ptr + k) % nm;
      if ((k < nm) && !found && req[idx[C_MAX_IDW-1:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ammrt_idfifo.sv
`default_nettype none
// ============================================================================
// Module      : ammrt_idfifo
// Description : Synchronous FIFO holding the master ID of each outstanding
//               read. Pointers carry one extra wrap bit for full/empty.
//               A push while full is accepted when a pop happens in the same
//               cycle.
// Ports       : clk, rst_n (sync, active-low)
//               push, din   - enqueue an ID
//               pop         - dequeue the head (ignored when empty)
//               full, empty - occupancy flags
//               head        - ID at the front of the queue
// Revision    : 1.0 - initial release
// ============================================================================
module ammrt_idfifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_WIDTH-1:0] din,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [P_WIDTH-1:0] head
);

  localparam int C_AW = $clog2(P_DEPTH);

  logic [C_AW:0]        r_wptr;
  logic [C_AW:0]        r_rptr;
  logic [P_WIDTH-1:0]   r_mem [P_DEPTH];
  logic                 w_do_pop;
  logic                 w_do_push;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                     (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rptr[C_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (C_AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (C_AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[C_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ammrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ammrt_arbiter
// Description : Round-robin arbiter sharing one Avalon-MM slave between
//               P_NM masters, with pipelined in-order reads. The ID of every
//               accepted read is queued so readdatavalid can be steered back
//               to the issuing master.
// Ports       : clk, rst_n           - clock, sync active-low reset
//               m_*                  - per-master command (slice i = master i)
//               m_waitrequest        - per-master stall
//               m_readdatavalid      - per-master response strobe
//               m_readdata           - slave readdata, broadcast
//               s_*                  - slave command / response
//               err_unexp_rdv        - sticky: response with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module ammrt_arbiter
  import ammrt_pkg::*;
#(
  parameter int P_NM      = 2,
  parameter int P_ASIZE   = 32,
  parameter int P_DBYTES  = 4,
  parameter int P_MAXPEND = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P_NM*P_ASIZE-1:0]      m_address,
  input  logic [P_NM*P_DBYTES*8-1:0]   m_writedata,
  input  logic [P_NM*P_DBYTES-1:0]     m_byteenable,
  input  logic [P_NM-1:0]              m_write,
  input  logic [P_NM-1:0]              m_read,
  output logic [P_NM-1:0]              m_waitrequest,
  output logic [P_NM-1:0]              m_readdatavalid,
  output logic [P_DBYTES*8-1:0]        m_readdata,
  output logic [P_ASIZE-1:0]           s_address,
  output logic [P_DBYTES*8-1:0]        s_writedata,
  output logic [P_DBYTES-1:0]          s_byteenable,
  output logic                         s_write,
  output logic                         s_read,
  input  logic                         s_waitrequest,
  input  logic                         s_readdatavalid,
  input  logic [P_DBYTES*8-1:0]        s_readdata,
  output logic                         err_unexp_rdv
);

  localparam int               C_IDW   = f_id_width(P_NM);
  localparam int               C_DW    = P_DBYTES * 8;
  localparam int               C_NSLOT = 1 << C_IDW;
  localparam logic [C_IDW-1:0] C_LAST  = C_IDW'(P_NM - 1);

  state_t              r_state, w_state_nxt;
  logic [C_IDW-1:0]    r_gnt, w_gnt_nxt;
  logic [C_IDW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic                r_err;
  logic [P_NM-1:0]     w_req;
  logic [C_MAX_NM-1:0] w_req8;
  logic [C_IDW-1:0]    w_win;
  logic                w_gnt_rd, w_gnt_wr;
  logic                w_cmd_rd, w_cmd_wr, w_accept;
  logic                w_push, w_pop;
  logic                w_fifo_full, w_fifo_empty;
  logic [C_IDW-1:0]    w_head;

  // Per-master command slices, padded to a power of two so any gnt value
  // indexes a defined entry
  logic [P_ASIZE-1:0]  w_addr_arr [C_NSLOT];
  logic [C_DW-1:0]     w_wdat_arr [C_NSLOT];
  logic [P_DBYTES-1:0] w_be_arr   [C_NSLOT];

  for (genvar gi = 0; gi < C_NSLOT; gi++) begin : g_slot
    if (gi < P_NM) begin : g_used
      assign w_addr_arr[gi] = m_address[gi*P_ASIZE +: P_ASIZE];
      assign w_wdat_arr[gi] = m_writedata[gi*C_DW +: C_DW];
      assign w_be_arr[gi]   = m_byteenable[gi*P_DBYTES +: P_DBYTES];
    end else begin : g_pad
      assign w_addr_arr[gi] = '0;
      assign w_wdat_arr[gi] = '0;
      assign w_be_arr[gi]   = '0;
    end
  end

  assign w_req = m_read | m_write;

  always_comb begin
    w_req8            = '0;
    w_req8[P_NM-1:0]  = w_req;
  end

  assign w_win    = C_IDW'(f_rr_winner(w_req8, int'(r_rr_ptr), P_NM));
  assign w_gnt_rd = m_read[r_gnt];
  assign w_gnt_wr = m_write[r_gnt];

  assign s_address    = w_addr_arr[r_gnt];
  assign s_writedata  = w_wdat_arr[r_gnt];
  assign s_byteenable = w_be_arr[r_gnt];
  assign s_read       = w_cmd_rd;
  assign s_write      = w_cmd_wr;

  // Next-state and command/stall outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_cmd_rd      = 1'b0;
    w_cmd_wr      = 1'b0;
    w_accept      = 1'b0;
    m_waitrequest = '1;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_gnt_nxt   = w_win;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Reads are held off while every ID slot is in use; a read+write
        // collision resolves as a read
        w_cmd_rd = w_gnt_rd & ~w_fifo_full;
        w_cmd_wr = w_gnt_wr & ~w_gnt_rd;
        m_waitrequest[r_gnt] = s_waitrequest | (w_gnt_rd & w_fifo_full);
        w_accept = (w_cmd_rd | w_cmd_wr) & ~s_waitrequest;
        if (w_accept) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_gnt == C_LAST) ? '0 : r_gnt + C_IDW'(1);
        end else if (!w_req[r_gnt]) begin
          // Master withdrew mid-stall: abandon without moving the pointer
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (s_readdatavalid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign w_push = w_accept & w_cmd_rd;
  assign w_pop  = s_readdatavalid & ~w_fifo_empty;

  ammrt_idfifo #(
    .P_DEPTH (P_MAXPEND),
    .P_WIDTH (C_IDW)
  ) u_idfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (r_gnt),
    .pop   (w_pop),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .head  (w_head)
  );

  // Response steering: only the master at the FIFO head sees the strobe
  always_comb begin
    m_readdatavalid = '0;
    if (w_pop) m_readdatavalid[w_head] = 1'b1;
  end

  assign m_readdata    = s_readdata;
  assign err_unexp_rdv = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ammrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ammrt_arbiter
// Description : Self-checking bench for ammrt_arbiter: directed scenarios
//               followed by randomized traffic, all compared cycle by cycle
//               against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ammrt_arbiter;

  localparam int NM = 3;
  localparam int AS = 32;
  localparam int DB = 4;
  localparam int DW = DB * 8;
  localparam int MP = 4;

  logic               clk;
  logic               rst_n;
  logic [NM*AS-1:0]   m_address;
  logic [NM*DW-1:0]   m_writedata;
  logic [NM*DB-1:0]   m_byteenable;
  logic [NM-1:0]      m_write;
  logic [NM-1:0]      m_read;
  logic [NM-1:0]      m_waitrequest;
  logic [NM-1:0]      m_readdatavalid;
  logic [DW-1:0]      m_readdata;
  logic [AS-1:0]      s_address;
  logic [DW-1:0]      s_writedata;
  logic [DB-1:0]      s_byteenable;
  logic               s_write;
  logic               s_read;
  logic               s_waitrequest;
  logic               s_readdatavalid;
  logic [DW-1:0]      s_readdata;
  logic               err_unexp_rdv;

  ammrt_arbiter #(
    .P_NM      (NM),
    .P_ASIZE   (AS),
    .P_DBYTES  (DB),
    .P_MAXPEND (MP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .s_address       (s_address),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_write         (s_write),
    .s_read          (s_read),
    .s_waitrequest   (s_waitrequest),
    .s_readdatavalid (s_readdatavalid),
    .s_readdata      (s_readdata),
    .err_unexp_rdv   (err_unexp_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: granted master (-1 = none), pointer, pending-ID queue
  int mdl_gnt;
  int mdl_ptr;
  int mdl_q[$];
  bit mdl_err;

  // DUT observations from the most recent tick
  logic          last_acc;
  int            last_acc_id;
  logic [NM-1:0] last_mrdv;
  logic [NM-1:0] last_wait;
  logic [DW-1:0] last_rdata;
  logic [AS-1:0] last_saddr;
  logic [DW-1:0] last_swdata;
  logic          last_sread;
  logic          last_swrite;
  logic          last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [NM-1:0] ew;
    logic [NM-1:0] erdv;
    logic esr, esw, rd, wr, full;
    ew   = '1;
    erdv = '0;
    esr  = 1'b0;
    esw  = 1'b0;
    full = (mdl_q.size() == MP);
    if (mdl_gnt >= 0) begin
      rd  = m_read[mdl_gnt];
      wr  = m_write[mdl_gnt] & ~rd;
      esr = rd & ~full;
      esw = wr;
      ew[mdl_gnt] = s_waitrequest | (rd & full);
    end
    if (s_readdatavalid && mdl_q.size() > 0) erdv[mdl_q[0]] = 1'b1;
    chk("s_read", s_read, esr);
    chk("s_write", s_write, esw);
    chk("m_waitrequest", m_waitrequest, ew);
    chk("m_readdatavalid", m_readdatavalid, erdv);
    chk("m_readdata", m_readdata, s_readdata);
    chk("err_unexp_rdv", err_unexp_rdv, mdl_err);
    if (mdl_gnt >= 0 && (esr || esw)) begin
      chk("s_address", s_address, m_address[mdl_gnt*AS +: AS]);
      chk("s_byteenable", s_byteenable, m_byteenable[mdl_gnt*DB +: DB]);
      if (esw) chk("s_writedata", s_writedata, m_writedata[mdl_gnt*DW +: DW]);
    end
    // capture what the DUT showed this cycle
    last_acc    = (s_read | s_write) & ~s_waitrequest;
    last_acc_id = -1;
    for (int i = 0; i < NM; i++) if (!m_waitrequest[i]) last_acc_id = i;
    last_mrdv   = m_readdatavalid;
    last_wait   = m_waitrequest;
    last_rdata  = m_readdata;
    last_saddr  = s_address;
    last_swdata = s_writedata;
    last_sread  = s_read;
    last_swrite = s_write;
    last_err    = err_unexp_rdv;
  endtask

  task automatic model_update();
    int   g;
    logic rd, wr, full, acc, found;
    if (!rst_n) begin
      mdl_gnt = -1;
      mdl_ptr = 0;
      mdl_q.delete();
      mdl_err = 1'b0;
    end else begin
      g    = mdl_gnt;
      full = (mdl_q.size() == MP);
      acc  = 1'b0;
      rd   = 1'b0;
      if (g >= 0) begin
        rd  = m_read[g];
        wr  = m_write[g] & ~rd;
        acc = ((rd & ~full) | wr) & ~s_waitrequest;
      end
      if (s_readdatavalid) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else mdl_err = 1'b1;
      end
      if (g < 0) begin
        found = 1'b0;
        for (int k = 0; k < NM; k++) begin
          int i;
          i = (mdl_ptr + k) % NM;
          if (!found && (m_read[i] || m_write[i])) begin
            mdl_gnt = i;
            found   = 1'b1;
          end
        end
      end else if (acc) begin
        mdl_gnt = -1;
        mdl_ptr = (g + 1) % NM;
        if (rd) mdl_q.push_back(g);
      end else if (!(m_read[g] || m_write[g])) begin
        mdl_gnt = -1;
      end
    end
  endtask

  // Inputs are driven at the falling edge; check shortly after, then
  // advance the model through the coming rising edge
  task automatic tick();
    #1;
    model_check();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_address       = '0;
    m_writedata     = '0;
    m_byteenable    = '0;
    m_write         = '0;
    m_read          = '0;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NM; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        m_read[i]  = (r < 4);
        m_write[i] = (r >= 4 && r < 7);
        m_address[i*AS +: AS]   = $urandom;
        m_writedata[i*DW +: DW] = $urandom;
        m_byteenable[i*DB +: DB] = DB'($urandom);
      end
    end
    s_waitrequest   = ($urandom_range(0, 2) == 0);
    s_readdatavalid = ($urandom_range(0, 3) == 0);
    s_readdata      = $urandom;
    rst_n           = ($urandom_range(0, 199) != 0);
  endtask

  int cnt [NM];
  int seq[$];
  int nacc;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    mdl_gnt = -1;
    mdl_ptr = 0;
    mdl_err = 1'b0;
    @(negedge clk);

    // Reset state and a single stalled write from master 1
    do_reset();
    tick();
    chk("rst_wait", last_wait, 3'b111);
    chk("rst_cmd", {last_sread, last_swrite}, 2'b00);
    chk("rst_rdv", last_mrdv, 3'b000);
    chk("rst_err", last_err, 1'b0);
    m_write[1] = 1'b1;
    m_address[1*AS +: AS]    = 32'h0000_0100;
    m_writedata[1*DW +: DW]  = 32'hA5A5_A5A5;
    m_byteenable[1*DB +: DB] = 4'hF;
    s_waitrequest = 1'b1;
    tick();
    chk("wr_req_cycle_swrite", last_swrite, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_stall_swrite", last_swrite, 1'b1);
      chk("wr_stall_wait", last_wait, 3'b111);
    end
    s_waitrequest = 1'b0;
    tick();
    chk("wr_acc_wait", last_wait, 3'b101);
    chk("wr_acc_addr", last_saddr, 32'h100);
    chk("wr_acc_data", last_swdata, 32'hA5A5_A5A5);
    m_write = '0;
    tick();
    chk("wr_after_idle", {last_swrite, last_wait}, {1'b0, 3'b111});

    // Masters 0 and 1 both requesting continuously
    do_reset();
    m_write = 3'b011;
    cnt = '{default: 0};
    seq.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (last_acc && last_acc_id >= 0) begin
        cnt[last_acc_id]++;
        seq.push_back(last_acc_id);
      end
    end
    chk("alt_cnt0", cnt[0], 4);
    chk("alt_cnt1", cnt[1], 4);
    chk("alt_nacc", seq.size(), 8);
    for (int k = 0; k < seq.size() && k < 8; k++) chk("alt_seq", seq[k], k % 2);

    // Five reads from master 0 with no responses: four fill the ID FIFO
    do_reset();
    m_read = 3'b001;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (last_acc) nacc++;
    end
    chk("rd5_naccepted", nacc, 4);
    tick();
    chk("rd5_stall_sread", last_sread, 1'b0);
    chk("rd5_stall_wait", last_wait[0], 1'b1);
    s_readdatavalid = 1'b1;
    s_readdata = 32'hD0;
    tick();
    chk("rd5_rdv", last_mrdv, 3'b001);
    chk("rd5_rdv_sread", last_sread, 1'b0);
    s_readdatavalid = 1'b0;
    tick();
    chk("rd5_release_sread", last_sread, 1'b1);
    chk("rd5_release_acc", last_acc, 1'b1);
    m_read = '0;
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1'b1;
      tick();
      chk("rd5_drain", last_mrdv, 3'b001);
    end
    s_readdatavalid = 1'b0;
    tick();
    chk("rd5_no_err", last_err, 1'b0);

    // Interleaved reads 1,0,1 with in-order responses
    do_reset();
    m_read = 3'b010;
    tick(); tick();
    chk("il_acc_a", last_acc_id, 1);
    m_read = 3'b001;
    tick(); tick();
    chk("il_acc_b", last_acc_id, 0);
    m_read = 3'b010;
    tick();
    s_readdatavalid = 1'b1;
    s_readdata = 32'h11;
    tick();
    chk("il_acc_c_pushpop", {last_acc, 2'(last_acc_id)}, {1'b1, 2'd1});
    chk("il_rdv1", last_mrdv, 3'b010);
    chk("il_dat1", last_rdata, 32'h11);
    m_read = '0;
    s_readdata = 32'h22;
    tick();
    chk("il_rdv2", last_mrdv, 3'b001);
    chk("il_dat2", last_rdata, 32'h22);
    s_readdata = 32'h33;
    tick();
    chk("il_rdv3", last_mrdv, 3'b010);
    chk("il_dat3", last_rdata, 32'h33);
    s_readdatavalid = 1'b0;
    tick();
    chk("il_quiet", {last_mrdv, last_err}, 4'b0000);

    // Unexpected readdatavalid
    do_reset();
    s_readdatavalid = 1'b1;
    tick();
    chk("unexp_rdv", last_mrdv, 3'b000);
    s_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("unexp_err_sticky", last_err, 1'b1);
    end
    do_reset();
    tick();
    chk("unexp_err_cleared", last_err, 1'b0);

    // Reset while a read is stalled; pointer restarts at master 0
    do_reset();
    m_write = 3'b010;
    tick(); tick();
    chk("rr_prep_acc", last_acc_id, 1);
    m_write = '0;
    m_read = 3'b100;
    s_waitrequest = 1'b1;
    tick(); tick();
    chk("rr_stall_sread", last_sread, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_read = 3'b111;
    s_waitrequest = 1'b0;
    tick();
    chk("rr_after_rst", {last_sread, last_wait}, {1'b0, 3'b111});
    tick();
    chk("rr_restart_0", last_acc_id, 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
